debounce_filter: RTL and testbench
==================================

Name: debounce_filter

Overview:
- Cleans a raw mechanical input, such as a push-button or slide switch, into a glitch-free level.
- Sits directly upstream of the positive-edge detector in the Counter design. Its `level` output drives the edge detector's level input, so each physical press yields exactly one count tick.
- Contains an optional two-flop synchronizer, a stability counter and a 4-state FSM.

Parameters:
- STABLE_CNT, 1000000, number of consecutive clk cycles the synchronized input must differ from `level` before `level` flips (10 ms at 100 MHz). Must be >= 2.
- CNT_W, 20, stability counter width. Must satisfy 2**CNT_W > STABLE_CNT-1. Violation is an elaboration-time error.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- btn_in, input, 1, raw, possibly bouncing and asynchronous input.
- level, output, 1, debounced level; registered.
- busy, output, 1, high while a candidate transition is being qualified (FSM in a WAIT state); registered.

Behaviour:
- Reset (rst_n low, asynchronous):
  - level=0, busy=0, counter=0, state=IDLE_LOW.
  - Synchronizer flops = 0.
  - Outputs hold these values until the first clk edge after rst_n deasserts.
- Sampled input `s`: output of the 2-flop synchronizer (DEBOUNCE_SYNC_EN defined) or btn_in directly (undefined).
- IDLE_LOW (level=0):
  - s=1 -> WAIT_HIGH, counter<=0, busy<=1.
  - Otherwise stay.
- WAIT_HIGH:
  - s=0 -> abort to IDLE_LOW, counter<=0, busy<=0, level unchanged.
  - Else if counter==STABLE_CNT-1 -> level<=1, state IDLE_HIGH, counter<=0, busy<=0.
  - Else counter<=counter+1.
- IDLE_HIGH and WAIT_LOW: mirror images of the above with polarity inverted.
- Abort takes priority over completion: if s reverts in the same cycle the counter reaches STABLE_CNT-1, level does not flip.
- Latency, btn_in change to level change, input held steady throughout:
  - STABLE_CNT+3 clk edges with sync.
  - STABLE_CNT+1 clk edges without sync.
- Any bounce restarts qualification from zero; there is no partial credit.
- Wrap-around: the counter never exceeds STABLE_CNT-1, so it never wraps.
- level changes at most once per qualification, and only via a WAIT state. Minimum spacing between level changes is STABLE_CNT+1 cycles.
- Reset mid-qualification discards progress: level returns to 0 even if it was 1.
- btn_in held constant from reset: level never changes, busy stays 0.

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN.
- Defined: 2-flop synchronizer on btn_in, both flops reset to 0 by rst_n. Use for truly asynchronous pins.
- Undefined: synchronizer omitted and btn_in feeds the FSM directly. The source must already be synchronous to clk. Latency drops by 2 cycles.

Decomposition:
- Package debounce_pkg holds:
  - state enum: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW (2-bit encoding);
  - default constants for STABLE_CNT and CNT_W.
- Sub-module sync_2ff (clk, rst_n, d, q) implements the synchronizer. It is instantiated only under DEBOUNCE_SYNC_EN and is reusable by other pin inputs.

Test Plan (STABLE_CNT=4, CNT_W=3, sync enabled unless noted):
- Reset check: rst_n low with btn_in=1 -> level=0, busy=0. After release, with btn_in held at 1, level=1 exactly 7 clk edges after first sampled edge.
- Clean press: btn_in 0->1 held -> busy rises at edge 3, level rises at edge 7, busy falls at edge 7. btn_in 1->0 held -> level falls 7 edges later.
- Bounce rejection: btn_in 1 for 3 cycles, 0 for 1, then 1 held -> busy drops on abort and level stays 0 through the glitch. level rises 7 edges after the final 0->1.
- Glitch shorter than STABLE_CNT: single-cycle pulse on btn_in -> level never changes; busy pulses for 1 cycle.
- Reset mid-qualification: assert rst_n low while busy=1 with counter=2 -> immediately level=0, busy=0. Requalification restarts from 0 after release.
- Sync disabled build: clean press -> level rises at edge 5 (STABLE_CNT+1).

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and default sizing for the debounce filter.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // 10 ms qualification window at 100 MHz
  localparam int STABLE_CNT_DEF = 1000000;
  localparam int CNT_W_DEF      = 20;

endpackage

// File: rtl/debounce_if.sv
// Raw input / debounced output bundle for debounce_filter.
interface debounce_if;
  logic btn_in;
  logic level;
  logic busy;

  modport master (output btn_in, input level, input busy);
  modport slave  (input btn_in, output level, output busy);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin; both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/debounce_filter.sv
// Debounces a mechanical input into a glitch-free registered level.
// Define DEBOUNCE_SYNC_EN to add a 2-flop synchronizer in front of the FSM.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = STABLE_CNT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  debounce_if.slave  dbif
);

  if (STABLE_CNT < 2) begin : g_bad_stable
    $error("debounce_filter: STABLE_CNT must be >= 2");
  end
  if (CNT_W < $clog2(STABLE_CNT)) begin : g_bad_width
    $error("debounce_filter: CNT_W too narrow to hold STABLE_CNT-1");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

  logic s;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dbif.btn_in),
    .q     (s)
  );
`else
  assign s = dbif.btn_in;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             level_q, level_d;
  logic             busy_q,  busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  // Abort is tested before completion so a revert on the final count never flips level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  assign dbif.level = level_q;
  assign dbif.busy  = busy_q;

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter; level transitions checked against a timed scoreboard.
module tb_debounce_filter;

  localparam int S = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = S + SYNC + 1;

  logic clk = 1'b0;
  logic rst_n;

  debounce_if bif ();

  debounce_filter #(.STABLE_CNT(S), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dbif  (bif)
  );

  always #5 clk = ~clk;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {int cyc; logic v;} ev_t;
  ev_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp_v);
    end
  endtask

  // Every level change must match the next expected (edge, value) entry.
  logic prev_level = 1'b0;
  always @(negedge clk) begin
    if (bif.level !== prev_level) begin
      prev_level = bif.level;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_level obs=%0b exp=no_change cyc=%0d", bif.level, cyc);
      end
      if (exp_q.size() != 0) begin
        ev_t e;
        e = exp_q.pop_front();
        chk("level_edge_cyc", cyc, e.cyc);
        chk("level_edge_val", {31'd0, bif.level}, {31'd0, e.v});
      end
    end
  end

  task automatic clean(input logic v);
    int t0;
    @(negedge clk);
    bif.btn_in = v;
    t0 = cyc;
    exp_q.push_back('{t0 + LAT, v});
    repeat (SYNC) @(negedge clk);
    chk("clean_busy_pre", bif.busy, 0);
    @(negedge clk);
    chk("clean_busy_on", bif.busy, 1);
    repeat (S - 1) @(negedge clk);
    chk("clean_busy_last", bif.busy, 1);
    chk("clean_level_hold", bif.level, {31'd0, ~v});
    @(negedge clk);
    chk("clean_busy_off", bif.busy, 0);
    chk("clean_level_new", bif.level, {31'd0, v});
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t0, tf;
    rst_n = 1'b0;
    bif.btn_in = 1'b1;
    #1;
    chk("rst_level", bif.level, 0);
    chk("rst_busy", bif.busy, 0);
    repeat (3) @(negedge clk);
    chk("rst_hold_level", bif.level, 0);
    chk("rst_hold_busy", bif.busy, 0);

    // release with input already high
    rst_n = 1'b1;
    t0 = cyc;
    exp_q.push_back('{t0 + LAT, 1'b1});
    repeat (LAT - 1) @(negedge clk);
    chk("post_rst_level_early", bif.level, 0);
    @(negedge clk);
    chk("post_rst_level", bif.level, 1);
    repeat (2) @(negedge clk);

    clean(1'b0);
    clean(1'b1);
    clean(1'b0);

    // bounce: 1 x3, 0 x1, then 1 held
    @(negedge clk);
    bif.btn_in = 1'b1;
    t0 = cyc;
    repeat (3) @(negedge clk);
    bif.btn_in = 1'b0;
    @(negedge clk);
    bif.btn_in = 1'b1;
    tf = cyc;
    exp_q.push_back('{tf + LAT, 1'b1});
    repeat (t0 + SYNC + 4 - cyc) @(negedge clk);
    chk("bounce_abort_busy", bif.busy, 0);
    chk("bounce_abort_level", bif.level, 0);
    repeat (tf + LAT - cyc - 1) @(negedge clk);
    chk("bounce_level_early", bif.level, 0);
    @(negedge clk);
    chk("bounce_level", bif.level, 1);
    chk("bounce_busy_off", bif.busy, 0);
    repeat (2) @(negedge clk);

    // low pulse exactly STABLE_CNT long: revert on final count must abort
    @(negedge clk);
    bif.btn_in = 1'b0;
    repeat (S) @(negedge clk);
    bif.btn_in = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    chk("edge_pulse_level", bif.level, 1);
    chk("edge_pulse_busy", bif.busy, 0);

    // single-cycle glitch
    @(negedge clk);
    bif.btn_in = 1'b0;
    @(negedge clk);
    bif.btn_in = 1'b1;
    repeat (SYNC) @(negedge clk);
    chk("glitch_busy_on", bif.busy, 1);
    @(negedge clk);
    chk("glitch_busy_off", bif.busy, 0);
    chk("glitch_level", bif.level, 1);
    repeat (3) @(negedge clk);

    clean(1'b0);

    // reset while qualifying a rise with counter at 2
    @(negedge clk);
    bif.btn_in = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    chk("midq_busy", bif.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midq_rst_level", bif.level, 0);
    chk("midq_rst_busy", bif.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    exp_q.push_back('{t0 + LAT, 1'b1});
    repeat (LAT - 1) @(negedge clk);
    chk("requal_restart", bif.level, 0);
    @(negedge clk);
    chk("requal_level", bif.level, 1);

    // reset while level is high drops it immediately
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bif.btn_in = 1'b0;
    exp_q.push_back('{cyc, 1'b0});
    #1;
    chk("hi_rst_level", bif.level, 0);
    chk("hi_rst_busy", bif.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk("const_busy", bif.busy, 0);
    end
    chk("const_level", bif.level, 0);

    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
